// File: rtl/ccip_rd_arbiter.sv
// Round-robin arbiter sharing the CCI-P C0 read Tx channel among NUM_REQ engines,
// with mdata-based response steering, outstanding-read tracking and flush handshake.
// Optional per-requester issue counters: define CCIP_RD_ARB_STATS_EN.
module ccip_rd_arbiter #(
   parameter int unsigned NUM_REQ         = 4,
   parameter int unsigned ADDR_W          = 42,
   parameter int unsigned TAG_W           = 8,
   parameter int unsigned DATA_W          = 512,
   parameter int unsigned MAX_OUTSTANDING = 64
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic [NUM_REQ-1:0]                     req_valid,
   output logic [NUM_REQ-1:0]                     req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]              req_addr,
   input  logic [NUM_REQ*TAG_W-1:0]               req_tag,
   output logic                                   tx_c0_valid,
   output logic [ADDR_W-1:0]                      tx_c0_addr,
   output logic [15:0]                            tx_c0_mdata,
   input  logic                                   tx_c0_almfull,
   input  logic                                   rx_c0_rsp_valid,
   input  logic [15:0]                            rx_c0_rsp_mdata,
   input  logic [DATA_W-1:0]                      rx_c0_rsp_data,
   output logic [NUM_REQ-1:0]                     rsp_valid,
   output logic [TAG_W-1:0]                       rsp_tag,
   output logic [DATA_W-1:0]                      rsp_data,
   input  logic                                   flush_req,
   output logic                                   flush_done,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
`ifdef CCIP_RD_ARB_STATS_EN
   ,
   input  logic [$clog2(NUM_REQ)-1:0]             stat_sel,
   output logic [31:0]                            stat_count
`endif
);

   localparam int unsigned IDW = $clog2(NUM_REQ);
   localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned CW1 = CW + 1;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_THROTTLE = 2'd1,
      ST_DRAIN    = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [IDW-1:0]      r_ptr;
   logic [IDW-1:0]      w_ptr_next;
   logic [IDW-1:0]      w_gnt_idx;
   logic                w_gnt_found;
   logic                w_issue_ok;
   logic                w_accept;
   logic [NUM_REQ-1:0]  w_ready;
   int unsigned         w_scan;
   logic [CW-1:0]       r_cnt;
   logic [CW-1:0]       w_cnt_next;
   logic [CW1-1:0]      w_inflight;
   logic                r_tx_valid;
   logic [ADDR_W-1:0]   r_tx_addr;
   logic [15:0]         r_tx_mdata;
   logic [15:0]         w_mdata;
   logic [IDW-1:0]      w_rsp_id;
   logic [NUM_REQ-1:0]  w_rsp_onehot;
   logic [NUM_REQ-1:0]  r_rsp_valid;
   logic [TAG_W-1:0]    r_rsp_tag;
   logic [DATA_W-1:0]   r_rsp_data;
   logic                r_flush_done;
   logic                w_flush_done_next;

   // First valid requester at or after the pointer, wrapping
   always_comb begin
      w_gnt_found = 1'b0;
      w_gnt_idx   = '0;
      w_scan      = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_scan = (32'(r_ptr) + i) % NUM_REQ;
         if (!w_gnt_found && req_valid[IDW'(w_scan)]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = IDW'(w_scan);
         end
      end
   end

   // Pending (registered, not yet counted) issue is included so the cap is never overshot
   assign w_inflight = CW1'(r_cnt) + CW1'(r_tx_valid);
   assign w_issue_ok = (r_state == ST_RUN) && !tx_c0_almfull && !flush_req &&
                       (w_inflight < CW1'(MAX_OUTSTANDING));

   always_comb begin
      w_ready = '0;
      if (w_issue_ok && w_gnt_found) w_ready[w_gnt_idx] = 1'b1;
   end

   assign w_accept   = |w_ready;
   assign w_ptr_next = (w_gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDW'(1);

   always_comb begin
      w_mdata                 = '0;
      w_mdata[TAG_W +: IDW]   = w_gnt_idx;
      w_mdata[TAG_W-1:0]      = req_tag[32'(w_gnt_idx)*TAG_W +: TAG_W];
   end

   // Outstanding count; a response with nothing counted (e.g. after reset) saturates at 0
   always_comb begin
      w_cnt_next = r_cnt;
      if (r_tx_valid && !rx_c0_rsp_valid)
         w_cnt_next = r_cnt + CW'(1);
      else if (!r_tx_valid && rx_c0_rsp_valid && (r_cnt != '0))
         w_cnt_next = r_cnt - CW'(1);
   end

   // Next state looks at the updated count so flush_done lines up with outstanding==0
   always_comb begin
      w_state_next      = r_state;
      w_flush_done_next = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (flush_req)
               w_state_next = ST_DRAIN;
            else if (tx_c0_almfull || (w_cnt_next == CW'(MAX_OUTSTANDING)))
               w_state_next = ST_THROTTLE;
         end
         ST_THROTTLE: begin
            if (flush_req)
               w_state_next = ST_DRAIN;
            else if (!tx_c0_almfull && (w_cnt_next != CW'(MAX_OUTSTANDING)))
               w_state_next = ST_RUN;
         end
         ST_DRAIN: begin
            if (w_cnt_next == '0) begin
               w_state_next      = ST_RUN;
               w_flush_done_next = 1'b1;
            end
         end
         default: w_state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_RUN;
      else       r_state <= w_state_next;
   end

   assign w_rsp_id = rx_c0_rsp_mdata[TAG_W +: IDW];

   always_comb begin
      w_rsp_onehot = '0;
      if (rx_c0_rsp_valid && (32'(w_rsp_id) < NUM_REQ)) w_rsp_onehot[w_rsp_id] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ptr        <= '0;
         r_cnt        <= '0;
         r_tx_valid   <= 1'b0;
         r_tx_addr    <= '0;
         r_tx_mdata   <= '0;
         r_rsp_valid  <= '0;
         r_rsp_tag    <= '0;
         r_rsp_data   <= '0;
         r_flush_done <= 1'b0;
      end else begin
         r_cnt        <= w_cnt_next;
         r_flush_done <= w_flush_done_next;
         r_tx_valid   <= w_accept;
         if (w_accept) begin
            r_tx_addr  <= req_addr[32'(w_gnt_idx)*ADDR_W +: ADDR_W];
            r_tx_mdata <= w_mdata;
            r_ptr      <= w_ptr_next;
         end
         r_rsp_valid <= w_rsp_onehot;
         if (rx_c0_rsp_valid) begin
            r_rsp_tag  <= rx_c0_rsp_mdata[TAG_W-1:0];
            r_rsp_data <= rx_c0_rsp_data;
         end
      end
   end

   generate
      if (TAG_W + IDW < 16) begin : g_mdata_pad
         logic w_unused_pad;
         assign w_unused_pad = ^rx_c0_rsp_mdata[15:TAG_W+IDW];
      end
   endgenerate

`ifdef CCIP_RD_ARB_STATS_EN
   logic [31:0] r_stat_cnt [NUM_REQ];
   logic [31:0] r_stat_count;

   // Per-requester wrapping issue counters with a registered read port
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) r_stat_cnt[i] <= '0;
         r_stat_count <= '0;
      end else begin
         if (w_accept) r_stat_cnt[w_gnt_idx] <= r_stat_cnt[w_gnt_idx] + 32'd1;
         r_stat_count <= (32'(stat_sel) < NUM_REQ) ? r_stat_cnt[stat_sel] : 32'd0;
      end
   end

   assign stat_count = r_stat_count;
`endif

   assign req_ready   = w_ready;
   assign tx_c0_valid = r_tx_valid;
   assign tx_c0_addr  = r_tx_addr;
   assign tx_c0_mdata = r_tx_mdata;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_tag     = r_rsp_tag;
   assign rsp_data    = r_rsp_data;
   assign flush_done  = r_flush_done;
   assign outstanding = r_cnt;

endmodule

// File: tb/tb_ccip_rd_arbiter.sv
// Scoreboard bench for ccip_rd_arbiter (NUM_REQ=4, MAX_OUTSTANDING=4).
module tb_ccip_rd_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned AW = 42;
   localparam int unsigned TW = 8;
   localparam int unsigned DW = 512;
   localparam int unsigned MO = 4;
   localparam int unsigned CW = $clog2(MO + 1);

   logic              clock = 1'b0;
   logic              reset;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*TW-1:0]  req_tag;
   logic              tx_c0_valid;
   logic [AW-1:0]     tx_c0_addr;
   logic [15:0]       tx_c0_mdata;
   logic              tx_c0_almfull;
   logic              rx_c0_rsp_valid;
   logic [15:0]       rx_c0_rsp_mdata;
   logic [DW-1:0]     rx_c0_rsp_data;
   logic [NR-1:0]     rsp_valid;
   logic [TW-1:0]     rsp_tag;
   logic [DW-1:0]     rsp_data;
   logic              flush_req;
   logic              flush_done;
   logic [CW-1:0]     outstanding;
`ifdef CCIP_RD_ARB_STATS_EN
   logic [1:0]        stat_sel = 2'd0;
   logic [31:0]       stat_count;
`endif

   ccip_rd_arbiter #(
      .NUM_REQ(NR), .ADDR_W(AW), .TAG_W(TW), .DATA_W(DW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_tag(req_tag),
      .tx_c0_valid(tx_c0_valid), .tx_c0_addr(tx_c0_addr), .tx_c0_mdata(tx_c0_mdata),
      .tx_c0_almfull(tx_c0_almfull),
      .rx_c0_rsp_valid(rx_c0_rsp_valid), .rx_c0_rsp_mdata(rx_c0_rsp_mdata),
      .rx_c0_rsp_data(rx_c0_rsp_data),
      .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
      .flush_req(flush_req), .flush_done(flush_done),
      .outstanding(outstanding)
`ifdef CCIP_RD_ARB_STATS_EN
      , .stat_sel(stat_sel), .stat_count(stat_count)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [AW-1:0] addr;
      logic [15:0]   mdata;
   } tx_exp_t;

   typedef struct {
      logic [NR-1:0] strobe;
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
   } rsp_exp_t;

   tx_exp_t  txq[$];
   rsp_exp_t rspq[$];
   tx_exp_t  mon_te;
   rsp_exp_t mon_re;
   int       n_checks = 0;
   int       n_errors = 0;

   function automatic logic [AW-1:0] addr_of(input int i);
      return AW'(42'h2_0000_1000) + AW'(i) * AW'(64);
   endfunction

   function automatic logic [TW-1:0] tag_of(input int i);
      case (i)
         0:       return 8'hA0;
         1:       return 8'hB1;
         2:       return 8'h5A;
         default: return 8'hC3;
      endcase
   endfunction

   function automatic logic [DW-1:0] data_of(input int n);
      return {16{32'hA5C3_0F1E ^ (32'(n) * 32'h0101_0101)}};
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Check the combinational grant for this cycle, record the issue it implies, advance one cycle
   task automatic cycle_chk(input string nm, input int exp_g);
      logic [NR-1:0] oh;
      tx_exp_t       e;
      #1;
      oh = '0;
      if (exp_g >= 0) oh = NR'(1) << exp_g;
      chk(nm, DW'(req_ready), DW'(oh));
      if (exp_g >= 0) begin
         e.addr  = addr_of(exp_g);
         e.mdata = (16'(exp_g) << TW) | 16'(tag_of(exp_g));
         txq.push_back(e);
      end
      @(negedge clock);
      rx_c0_rsp_valid = 1'b0;
   endtask

   task automatic drive_rsp(input int id, input int n);
      rsp_exp_t r;
      rx_c0_rsp_valid = 1'b1;
      rx_c0_rsp_mdata = (16'(id) << TW) | 16'(tag_of(id));
      rx_c0_rsp_data  = data_of(n);
      r.strobe = NR'(1) << id;
      r.tag    = tag_of(id);
      r.data   = data_of(n);
      rspq.push_back(r);
   endtask

   always @(negedge clock) begin
      if (tx_c0_valid === 1'b1) begin
         if (txq.size() == 0) chk("tx_unexpected", DW'(tx_c0_valid), DW'(0));
         else begin
            mon_te = txq.pop_front();
            chk("tx_addr", DW'(tx_c0_addr), DW'(mon_te.addr));
            chk("tx_mdata", DW'(tx_c0_mdata), DW'(mon_te.mdata));
         end
      end
      if (rsp_valid !== '0 && !$isunknown(rsp_valid)) begin
         if (rspq.size() == 0) chk("rsp_unexpected", DW'(rsp_valid), DW'(0));
         else begin
            mon_re = rspq.pop_front();
            chk("rsp_strobe", DW'(rsp_valid), DW'(mon_re.strobe));
            chk("rsp_tag", DW'(rsp_tag), DW'(mon_re.tag));
            chk("rsp_data", rsp_data, mon_re.data);
         end
      end
   end

   initial begin
      reset           = 1'b1;
      req_valid       = '0;
      tx_c0_almfull   = 1'b0;
      rx_c0_rsp_valid = 1'b0;
      rx_c0_rsp_mdata = '0;
      rx_c0_rsp_data  = '0;
      flush_req       = 1'b0;
      for (int i = 0; i < NR; i++) begin
         req_addr[i*AW +: AW] = addr_of(i);
         req_tag[i*TW +: TW]  = tag_of(i);
      end
      repeat (3) @(negedge clock);
      chk("rst_txv",   DW'(tx_c0_valid), DW'(0));
      chk("rst_mdata", DW'(tx_c0_mdata), DW'(0));
      chk("rst_out",   DW'(outstanding), DW'(0));
      chk("rst_rspv",  DW'(rsp_valid),   DW'(0));
      chk("rst_fd",    DW'(flush_done),  DW'(0));
      reset = 1'b0;

      // Round robin over all four, then the outstanding cap
      req_valid = 4'hF;
      cycle_chk("rr_g0", 0);
      cycle_chk("rr_g1", 1);
      cycle_chk("rr_g2", 2);
      cycle_chk("rr_g3", 3);
      cycle_chk("rr_cap_a", -1);
      chk("out_cap", DW'(outstanding), DW'(4));
      cycle_chk("rr_cap_b", -1);
      drive_rsp(0, 1);
      cycle_chk("rr_cap_c", -1);
      cycle_chk("rr_wrap0", 0);
      req_valid = '0;
      drive_rsp(1, 2);
      cycle_chk("idle_simul", -1);
      chk("out_simul", DW'(outstanding), DW'(3));
      drive_rsp(2, 3);
      cycle_chk("idle_r2", -1);
      drive_rsp(3, 4);
      cycle_chk("idle_r3", -1);
      drive_rsp(0, 5);
      cycle_chk("idle_r0", -1);
      chk("out_zero", DW'(outstanding), DW'(0));

      // Almost-full back-pressure, then a sparse request pattern
      req_valid     = 4'hF;
      tx_c0_almfull = 1'b1;
      cycle_chk("af_a", -1);
      cycle_chk("af_b", -1);
      cycle_chk("af_c", -1);
      tx_c0_almfull = 1'b0;
      cycle_chk("af_lag", -1);
      cycle_chk("af_resume", 1);
      req_valid = 4'b1010;
      cycle_chk("sparse_3", 3);
      cycle_chk("sparse_1", 1);
      req_valid = '0;
      cycle_chk("sparse_idle", -1);
      chk("out_sparse", DW'(outstanding), DW'(3));
      drive_rsp(1, 6);
      cycle_chk("sp_r1", -1);
      drive_rsp(3, 7);
      cycle_chk("sp_r3", -1);
      drive_rsp(1, 8);
      cycle_chk("sp_r1b", -1);
      chk("out_sparse0", DW'(outstanding), DW'(0));

      // Flush with three reads in flight
      req_valid = 4'hF;
      cycle_chk("fl_g2", 2);
      cycle_chk("fl_g3", 3);
      cycle_chk("fl_g0", 0);
      flush_req = 1'b1;
      cycle_chk("fl_block", -1);
      flush_req = 1'b0;
      chk("out_fl", DW'(outstanding), DW'(3));
      chk("fd_a", DW'(flush_done), DW'(0));
      cycle_chk("fl_drain_a", -1);
      chk("fd_b", DW'(flush_done), DW'(0));
      drive_rsp(2, 9);
      cycle_chk("fl_drain_b", -1);
      chk("fd_c", DW'(flush_done), DW'(0));
      drive_rsp(3, 10);
      cycle_chk("fl_drain_c", -1);
      chk("fd_d", DW'(flush_done), DW'(0));
      drive_rsp(0, 11);
      cycle_chk("fl_drain_d", -1);
      req_valid = '0;
      chk("fd_pulse", DW'(flush_done), DW'(1));
      chk("out_fl0", DW'(outstanding), DW'(0));
      cycle_chk("fl_idle", -1);
      chk("fd_clear", DW'(flush_done), DW'(0));

      // Reset with reads in flight; late response still forwarded, pointer back to 0
      req_valid = 4'hF;
      cycle_chk("rs_g1", 1);
      cycle_chk("rs_g2", 2);
      cycle_chk("rs_g3", 3);
      cycle_chk("rs_g0", 0);
      req_valid = '0;
      chk("out_pre_rst", DW'(outstanding), DW'(3));
      reset = 1'b1;
      cycle_chk("rs_hold", -1);
      reset = 1'b0;
      chk("rst2_out", DW'(outstanding), DW'(0));
      chk("rst2_txv", DW'(tx_c0_valid), DW'(0));
      drive_rsp(1, 12);
      cycle_chk("rs_late_rsp", -1);
      chk("out_sat", DW'(outstanding), DW'(0));
      req_valid = 4'hF;
      cycle_chk("rs_ptr0", 0);
      req_valid = '0;
      cycle_chk("tail_a", -1);
      cycle_chk("tail_b", -1);

      chk("txq_drained",  DW'(txq.size()),  DW'(0));
      chk("rspq_drained", DW'(rspq.size()), DW'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
